// File: rtl/bp_be_rec_to_fp.sv
// bp_be_rec_to_fp
//   Converts a HardFloat recoded double (65 bits) into an IEEE-754 binary64
//   value, or into a NaN-boxed binary32 value when raw_sp_not_dp_i is set.
//   The conversion is combinational. It is followed by latency_p register
//   stages that carry {v, raw}.
//
//   Optional feature (macro BP_REC_TO_FP_COUNTER_EN):
//     When the macro is defined, a conversion counter counts input-side valids.
//     When the macro is undefined, count_o is tied to 0 and clear_i is ignored.
//
// Parameters
//   latency_p  number of output register stages (0 = combinational)
//   max_val_p  terminal value of the counter; the counter wraps to 0 after it
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   reset_i          asynchronous, active-low reset
//   v_i              input valid
//   rec_i[64:0]      recoded double: sign [64], exp [63:52], sig [51:0]
//   raw_sp_not_dp_i  1 = NaN-boxed binary32, 0 = binary64
//   clear_i          synchronous counter clear
//   raw_o[63:0]      IEEE-754 result
//   v_o              output valid
//   count_o          conversion count
module bp_be_rec_to_fp #(
    parameter int latency_p = 1,
    parameter int max_val_p = 2**30,
    localparam int cnt_w_lp = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [64:0]         rec_i,
    input  logic                raw_sp_not_dp_i,
    input  logic                clear_i,
    output logic [63:0]         raw_o,
    output logic                v_o,
    output logic [cnt_w_lp-1:0] count_o
);

    // ------------------------------------------------------------------
    // Combinational conversion
    // ------------------------------------------------------------------
    logic        sign;
    logic [11:0] exp;
    logic [51:0] sig;

    assign sign = rec_i[64];
    assign exp  = rec_i[63:52];
    assign sig  = rec_i[51:0];

    logic [11:0] dp_exp_full;   // E + 1023 = exp - 1025
    logic [11:0] dp_shift;      // k = 1026 - exp (meaningful only when subnormal)
    logic [52:0] dp_mant_sh;
    logic [11:0] sp_exp_full;   // E + 127 = exp - 1921
    logic [11:0] sp_shift;      // -126 - E = 1922 - exp
    logic [23:0] sp_mant_sh;
    logic [63:0] dp_raw;
    logic [31:0] sp_raw;
    logic [63:0] conv_raw;

    assign dp_exp_full = exp - 12'd1025;
    assign dp_shift    = 12'd1026 - exp;
    assign dp_mant_sh  = {1'b1, sig} >> dp_shift[5:0];
    assign sp_exp_full = exp - 12'd1921;
    assign sp_shift    = 12'd1922 - exp;
    assign sp_mant_sh  = {1'b1, sig[51:29]} >> sp_shift[4:0];

    always_comb begin
        dp_raw = '0;
        sp_raw = '0;
        unique case (exp[11:9])
            3'b000: begin
                dp_raw = {sign, 63'b0};
                sp_raw = {sign, 31'b0};
            end
            3'b110: begin
                dp_raw = {sign, 11'h7FF, 52'b0};
                sp_raw = {sign, 8'hFF, 23'b0};
            end
            3'b111: begin
                dp_raw = {sign, 11'h7FF, sig};
                // Force the quiet bit so a truncated payload never becomes infinity.
                sp_raw = {sign, 8'hFF, 1'b1, sig[50:29]};
            end
            default: begin
                if (exp >= 12'd1026) begin
                    dp_raw = {sign, dp_exp_full[10:0], sig};
                end else if (dp_shift > 12'd52) begin
                    dp_raw = {sign, 63'b0};
                end else begin
                    dp_raw = {sign, 11'h0, dp_mant_sh[51:0]};
                end

                // Single precision truncates sig[28:0]; no rounding is done.
                if (exp >= 12'd1922) begin
                    sp_raw = {sign, sp_exp_full[7:0], sig[51:29]};
                end else if (sp_shift > 12'd23) begin
                    sp_raw = {sign, 31'b0};
                end else begin
                    sp_raw = {sign, 8'h0, sp_mant_sh[22:0]};
                end
            end
        endcase
        conv_raw = raw_sp_not_dp_i ? {32'hFFFF_FFFF, sp_raw} : dp_raw;
    end

    // ------------------------------------------------------------------
    // Output stages: free-running shift, raw moves regardless of valid
    // ------------------------------------------------------------------
    if (latency_p == 0) begin : g_comb
        assign v_o   = v_i;
        assign raw_o = conv_raw;
    end else begin : g_pipe
        logic [latency_p-1:0] v_q;
        logic [latency_p-1:0] v_d;
        logic [63:0]          raw_q [latency_p];
        logic [63:0]          raw_d [latency_p];

        for (genvar gi = 0; gi < latency_p; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign v_d[gi]   = v_i;
                assign raw_d[gi] = conv_raw;
            end else begin : g_next
                assign v_d[gi]   = v_q[gi-1];
                assign raw_d[gi] = raw_q[gi-1];
            end

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    v_q[gi]   <= 1'b0;
                    raw_q[gi] <= '0;
                end else begin
                    v_q[gi]   <= v_d[gi];
                    raw_q[gi] <= raw_d[gi];
                end
            end
        end

        assign v_o   = v_q[latency_p-1];
        assign raw_o = raw_q[latency_p-1];
    end

    // ------------------------------------------------------------------
    // Conversion counter (input side, independent of latency_p)
    // ------------------------------------------------------------------
`ifdef BP_REC_TO_FP_COUNTER_EN
    localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(max_val_p);

    logic [cnt_w_lp-1:0] count_q;
    logic [cnt_w_lp-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = v_i ? cnt_w_lp'(1) : '0;
        end else if (v_i) begin
            count_d = (count_q == max_lp) ? '0 : count_q + cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
`else
    logic unused_clear;
    assign unused_clear = clear_i;
    assign count_o      = '0;
`endif

endmodule

// File: tb/tb_bp_be_rec_to_fp.sv
// Self-checking bench for bp_be_rec_to_fp.
// Two instances share the inputs: u_l1 (latency 1, default max) and
// u_l2 (latency 2, max_val_p = 3, so the counter wrap can be reached quickly).
module tb_bp_be_rec_to_fp;

`ifdef BP_REC_TO_FP_COUNTER_EN
    localparam bit cnt_en_lp = 1'b1;
`else
    localparam bit cnt_en_lp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        v_i;
    logic [64:0] rec_i;
    logic        sp_i;
    logic        clear_i;

    logic [63:0] raw1, raw2;
    logic        v1, v2;
    logic [30:0] cnt1;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    bp_be_rec_to_fp #(.latency_p(1)) u_l1 (
        .clk_i(clk), .reset_i(reset_n), .v_i(v_i), .rec_i(rec_i),
        .raw_sp_not_dp_i(sp_i), .clear_i(clear_i),
        .raw_o(raw1), .v_o(v1), .count_o(cnt1)
    );

    bp_be_rec_to_fp #(.latency_p(2), .max_val_p(3)) u_l2 (
        .clk_i(clk), .reset_i(reset_n), .v_i(v_i), .rec_i(rec_i),
        .raw_sp_not_dp_i(sp_i), .clear_i(clear_i),
        .raw_o(raw2), .v_o(v2), .count_o(cnt2)
    );

    typedef struct {
        logic [64:0] rec;
        logic        sp;
        logic [63:0] exp_raw;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) begin
            passed++;
            $display("check %s: got %h", name, act);
        end else begin
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] cexp(input int v);
        return cnt_en_lp ? 64'(v) : 64'd0;
    endfunction

    initial begin
        vecs[0]  = '{{1'b0, 12'h800, 52'h0},             1'b0, 64'h3FF0000000000000};
        vecs[1]  = '{{1'b0, 12'h800, 52'h0},             1'b1, 64'hFFFFFFFF3F800000};
        vecs[2]  = '{{1'b0, 12'hC00, 52'h0},             1'b0, 64'h7FF0000000000000};
        vecs[3]  = '{{1'b0, 12'h3CE, 52'h0},             1'b0, 64'h0000000000000001};
        vecs[4]  = '{{1'b1, 12'h000, 52'h0},             1'b0, 64'h8000000000000000};
        vecs[5]  = '{{1'b0, 12'hE00, 52'h8000000000000}, 1'b0, 64'h7FF8000000000000};
        vecs[6]  = '{{1'b1, 12'hE00, 52'h0000000000001}, 1'b1, 64'hFFFFFFFFFFC00000};
        vecs[7]  = '{{1'b1, 12'hC00, 52'h0},             1'b1, 64'hFFFFFFFFFF800000};
        vecs[8]  = '{{1'b1, 12'h000, 52'h0000000000123}, 1'b1, 64'hFFFFFFFF80000000};
        vecs[9]  = '{{1'b1, 12'h801, 52'h8000000000000}, 1'b0, 64'hC008000000000000};
        vecs[10] = '{{1'b0, 12'h401, 52'h0},             1'b0, 64'h0008000000000000};
        vecs[11] = '{{1'b0, 12'h3CD, 52'h0},             1'b0, 64'h0000000000000000};
        vecs[12] = '{{1'b0, 12'h402, 52'h0},             1'b0, 64'h0010000000000000};
        vecs[13] = '{{1'b0, 12'h781, 52'h0},             1'b1, 64'hFFFFFFFF00400000};
        vecs[14] = '{{1'b0, 12'h76B, 52'h0},             1'b1, 64'hFFFFFFFF00000001};
        vecs[15] = '{{1'b0, 12'h76A, 52'h0},             1'b1, 64'hFFFFFFFF00000000};
        vecs[16] = '{{1'b0, 12'h800, 52'hFFFFFFFFFFFFF}, 1'b1, 64'hFFFFFFFF3FFFFFFF};
        vecs[17] = '{{1'b0, 12'h782, 52'h0},             1'b1, 64'hFFFFFFFF00800000};

        reset_n = 1'b0;
        v_i     = 1'b1;
        rec_i   = vecs[0].rec;
        sp_i    = 1'b0;
        clear_i = 1'b0;

        // Reset state, held across a clock edge with valid input present
        #12;
        chk("rst_v1",   64'(v1),   64'd0);
        chk("rst_raw1", raw1,      64'd0);
        chk("rst_v2",   64'(v2),   64'd0);
        chk("rst_raw2", raw2,      64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
        @(posedge clk); #1;
        v_i = 1'b0;
        reset_n = 1'b1;

        // Table-driven stream: one vector per cycle
        for (int i = 0; i < NV; i++) begin
            v_i   = 1'b1;
            rec_i = vecs[i].rec;
            sp_i  = vecs[i].sp;
            @(posedge clk); #1;
            chk($sformatf("l1_v[%0d]", i),   64'(v1), 64'd1);
            chk($sformatf("l1_raw[%0d]", i), raw1, vecs[i].exp_raw);
            if (i > 0) begin
                chk($sformatf("l2_v[%0d]", i - 1),   64'(v2), 64'd1);
                chk($sformatf("l2_raw[%0d]", i - 1), raw2, vecs[i-1].exp_raw);
            end
        end

        // Raw data shifts even without valid
        v_i   = 1'b0;
        rec_i = vecs[9].rec;
        sp_i  = vecs[9].sp;
        @(posedge clk); #1;
        chk("l1_novalid_v",   64'(v1), 64'd0);
        chk("l1_novalid_raw", raw1, vecs[9].exp_raw);
        chk("l2_last_v",      64'(v2), 64'd1);
        chk("l2_last_raw",    raw2, vecs[NV-1].exp_raw);
        @(posedge clk); #1;
        chk("l2_novalid_v",   64'(v2), 64'd0);
        chk("l2_novalid_raw", raw2, vecs[9].exp_raw);

        // Counter: clear alone, then 5 increments (l2 wraps at 3), then clear+inc
        clear_i = 1'b1;
        @(posedge clk); #1;
        chk("cnt1_clear", 64'(cnt1), cexp(0));
        chk("cnt2_clear", 64'(cnt2), cexp(0));
        clear_i = 1'b0;
        v_i     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("cnt1_five", 64'(cnt1), cexp(5));
        chk("cnt2_wrap", 64'(cnt2), cexp(1));
        clear_i = 1'b1;
        @(posedge clk); #1;
        chk("cnt1_clr_inc", 64'(cnt1), cexp(1));
        chk("cnt2_clr_inc", 64'(cnt2), cexp(1));
        clear_i = 1'b0;
        v_i     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset asserted mid-stream on the latency-2 path
        v_i   = 1'b1;
        rec_i = vecs[0].rec;
        sp_i  = vecs[0].sp;
        @(posedge clk); #1;
        rec_i = vecs[1].rec;
        sp_i  = vecs[1].sp;
        @(posedge clk); #1;
        chk("mid_v2_before", 64'(v2), 64'd1);
        rec_i = vecs[2].rec;
        sp_i  = vecs[2].sp;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_v2",   64'(v2),   64'd0);
        chk("mid_rst_raw2", raw2,      64'd0);
        chk("mid_rst_v1",   64'(v1),   64'd0);
        chk("mid_rst_cnt1", 64'(cnt1), 64'd0);
        v_i = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle_v2", 64'(v2), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_idle2_v2", 64'(v2), 64'd0);
        v_i   = 1'b1;
        rec_i = vecs[3].rec;
        sp_i  = vecs[3].sp;
        @(posedge clk); #1;
        v_i = 1'b0;
        chk("post_rst_lat1_v2", 64'(v2), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_lat2_v2",   64'(v2), 64'd1);
        chk("post_rst_lat2_raw2", raw2, vecs[3].exp_raw);
        chk("post_rst_cnt1",      64'(cnt1), cexp(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
